// File: rtl/spi_arbiter_pkg.sv
// rtl/spi_arbiter_pkg.sv - shared SPI slave selects, arbiter state and requester indices
package spi_arbiter_pkg;

   typedef enum logic [1:0] {
      SS_NONE    = 2'd0,
      SS_GAIN    = 2'd1,
      SS_TRIGGER = 2'd2,
      SS_EEPROM  = 2'd3
   } SlaveSelect;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_DONE,
      GAP
   } ArbState;

   localparam int RQ_CMD = 0;
   localparam int RQ_CAL = 1;

endpackage

// File: rtl/spi_req_hold.sv
// rtl/spi_req_hold.sv - per-requester request latch with pending and sticky overflow flags
module spi_req_hold
   import spi_arbiter_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        wrt,
   input  SlaveSelect  ss,
   input  logic [15:0] data,
   input  logic        clear,
   output logic        pend,
   output logic        ovf,
   output SlaveSelect  held_ss,
   output logic [15:0] held_data
);

   always_ff @(posedge clk) begin
      if (rst) begin
         pend      <= 1'b0;
         ovf       <= 1'b0;
         held_ss   <= SS_NONE;
         held_data <= 16'h0000;
      end else begin
         // a new pulse is accepted in the same cycle the slot is being emptied
         if (wrt && (!pend || clear)) begin
            held_ss   <= ss;
            held_data <= data;
            pend      <= 1'b1;
         end else if (clear) begin
            pend <= 1'b0;
         end
         if (wrt && pend && !clear) begin
            ovf <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/spi_arbiter.sv
// rtl/spi_arbiter.sv - two-requester SPI master arbiter with lock, lock timeout and inter-transaction gap
module spi_arbiter
   import spi_arbiter_pkg::*;
#(
   parameter int GAP_CYCLES = 4,
   parameter int LOCK_TMO   = 255
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  rq_wrt,
   input  SlaveSelect  rq_ss0,
   input  SlaveSelect  rq_ss1,
   input  logic [15:0] rq_data0,
   input  logic [15:0] rq_data1,
   input  logic [1:0]  rq_lock,
   output logic [1:0]  rq_done,
   output logic [1:0]  rq_pend,
   output logic [1:0]  rq_ovf,
   output logic        wrt_SPI,
   output SlaveSelect  ss,
   output logic [15:0] SPI_data,
   input  logic        SPI_done,
   output logic        owner
);

   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int LW = $clog2(LOCK_TMO + 1);

   ArbState       state;
   logic          last_grant;
   logic          lock_held;
   logic [GW-1:0] gap_cnt;
   logic [LW-1:0] lock_cnt;

   SlaveSelect    h_ss   [2];
   logic [15:0]   h_data [2];
   logic [1:0]    clear;
   logic          cand;
   logic          cand_ok;

   assign clear[RQ_CMD] = (state == ISSUE) && (owner == 1'b0);
   assign clear[RQ_CAL] = (state == ISSUE) && (owner == 1'b1);

   spi_req_hold u_hold_cmd (
      .clk       (clk),
      .rst       (rst),
      .wrt       (rq_wrt[RQ_CMD]),
      .ss        (rq_ss0),
      .data      (rq_data0),
      .clear     (clear[RQ_CMD]),
      .pend      (rq_pend[RQ_CMD]),
      .ovf       (rq_ovf[RQ_CMD]),
      .held_ss   (h_ss[RQ_CMD]),
      .held_data (h_data[RQ_CMD])
   );

   spi_req_hold u_hold_cal (
      .clk       (clk),
      .rst       (rst),
      .wrt       (rq_wrt[RQ_CAL]),
      .ss        (rq_ss1),
      .data      (rq_data1),
      .clear     (clear[RQ_CAL]),
      .pend      (rq_pend[RQ_CAL]),
      .ovf       (rq_ovf[RQ_CAL]),
      .held_ss   (h_ss[RQ_CAL]),
      .held_data (h_data[RQ_CAL])
   );

   // while locked only the owner may be granted; otherwise alternate on contention
   always_comb begin
      cand    = owner;
      cand_ok = 1'b0;
      if (lock_held) begin
         cand    = owner;
         cand_ok = rq_pend[owner];
      end else if (rq_pend[0] && rq_pend[1]) begin
         cand    = ~last_grant;
         cand_ok = 1'b1;
      end else if (rq_pend[0]) begin
         cand    = 1'b0;
         cand_ok = 1'b1;
      end else if (rq_pend[1]) begin
         cand    = 1'b1;
         cand_ok = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         rq_done    <= 2'b00;
         wrt_SPI    <= 1'b0;
         ss         <= SS_NONE;
         SPI_data   <= 16'h0000;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         lock_held  <= 1'b0;
         gap_cnt    <= '0;
         lock_cnt   <= '0;
      end else begin
         wrt_SPI <= 1'b0;
         rq_done <= 2'b00;
         case (state)
            IDLE: begin
               if (lock_held && !rq_pend[owner]) begin
                  if (lock_cnt == LW'(LOCK_TMO)) begin
                     lock_held <= 1'b0;
                     lock_cnt  <= '0;
                  end else begin
                     lock_cnt <= lock_cnt + LW'(1);
                  end
               end
               if (cand_ok) begin
                  state      <= ISSUE;
                  owner      <= cand;
                  last_grant <= cand;
                  wrt_SPI    <= 1'b1;
                  ss         <= h_ss[cand];
                  SPI_data   <= h_data[cand];
               end
            end
            ISSUE: begin
               state <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (SPI_done) begin
                  rq_done[owner] <= 1'b1;
                  lock_held      <= rq_lock[owner];
                  lock_cnt       <= '0;
                  ss             <= SS_NONE;
                  SPI_data       <= 16'h0000;
                  gap_cnt        <= '0;
                  state          <= (GAP_CYCLES > 0) ? GAP : IDLE;
               end
            end
            GAP: begin
               if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                  state <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt + GW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_arbiter.sv
// tb/tb_spi_arbiter.sv - directed table-driven and sequence checks for spi_arbiter
module tb_spi_arbiter;
   import spi_arbiter_pkg::*;

   logic        clk;
   logic        rst;
   logic [1:0]  rq_wrt;
   SlaveSelect  rq_ss0, rq_ss1;
   logic [15:0] rq_data0, rq_data1;
   logic [1:0]  rq_lock;
   logic [1:0]  rq_done, rq_pend, rq_ovf;
   logic        wrt_SPI;
   SlaveSelect  ss;
   logic [15:0] SPI_data;
   logic        SPI_done;
   logic        owner;

   int cyc = 0;
   int n_tests = 0;
   int n_fail = 0;

   spi_arbiter #(.GAP_CYCLES(4), .LOCK_TMO(8)) dut (
      .clk(clk), .rst(rst), .rq_wrt(rq_wrt),
      .rq_ss0(rq_ss0), .rq_ss1(rq_ss1),
      .rq_data0(rq_data0), .rq_data1(rq_data1),
      .rq_lock(rq_lock), .rq_done(rq_done), .rq_pend(rq_pend), .rq_ovf(rq_ovf),
      .wrt_SPI(wrt_SPI), .ss(ss), .SPI_data(SPI_data), .SPI_done(SPI_done),
      .owner(owner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got cycle %0d required < 30000", cyc);
      $fatal(1);
   end

   typedef struct {
      int          idx;
      SlaveSelect  sel;
      logic [15:0] data;
      int          done_off;
   } vec_t;

   vec_t vecs [4];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic pulse(input logic [1:0] m);
      rq_wrt = m;
      step();
      rq_wrt = 2'b00;
   endtask

   task automatic wait_wrt(input string nm, output int at);
      at = -1;
      for (int k = 0; k < 60; k++) begin
         if (wrt_SPI) begin
            at = cyc;
            break;
         end
         step();
      end
      if (at < 0) chk({nm, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic serve(input string nm, input logic o, input logic [15:0] d, input SlaveSelect s,
                        output int wrt_at, output int done_at);
      wait_wrt(nm, wrt_at);
      chk({nm, "_owner"}, 32'(owner), 32'(o));
      chk({nm, "_data"}, 32'(SPI_data), 32'(d));
      chk({nm, "_ss"}, 32'(ss), 32'(s));
      step();
      SPI_done = 1'b1;
      done_at  = cyc;
      step();
      SPI_done = 1'b0;
      chk({nm, "_done"}, 32'(rq_done), (o ? 32'd2 : 32'd1));
   endtask

   int c, w, d, w2, d2, w3, d3;

   initial begin
      vecs[0] = '{0, SS_TRIGGER, 16'h1380, 20};
      vecs[1] = '{1, SS_GAIN,    16'hA5C3, 5};
      vecs[2] = '{0, SS_EEPROM,  16'hFFFF, 3};
      vecs[3] = '{1, SS_EEPROM,  16'h0001, 8};

      rst = 1'b1; rq_wrt = 2'b00; rq_lock = 2'b00; SPI_done = 1'b0;
      rq_ss0 = SS_NONE; rq_ss1 = SS_NONE; rq_data0 = 16'h0; rq_data1 = 16'h0;
      repeat (3) step();
      rst = 1'b0;
      chk("rst_wrt", 32'(wrt_SPI), 0);
      chk("rst_ss", 32'(ss), 32'(SS_NONE));
      chk("rst_data", 32'(SPI_data), 0);
      chk("rst_pend_ovf_done", {26'd0, rq_pend, rq_ovf, rq_done}, 0);
      chk("rst_owner", 32'(owner), 0);

      while (cyc < 10) step();

      // single requests, idle arbiter: wrt_SPI two cycles after rq_wrt
      for (int v = 0; v < 4; v++) begin
         c = cyc;
         if (vecs[v].idx == 0) begin rq_ss0 = vecs[v].sel; rq_data0 = vecs[v].data; end
         else begin rq_ss1 = vecs[v].sel; rq_data1 = vecs[v].data; end
         pulse(2'(1 << vecs[v].idx));
         chk("vec_pend", 32'(rq_pend), 32'(1 << vecs[v].idx));
         chk("vec_no_early_wrt", 32'(wrt_SPI), 0);
         step();
         chk("vec_wrt", 32'(wrt_SPI), 1);
         chk("vec_ss", 32'(ss), 32'(vecs[v].sel));
         chk("vec_data", 32'(SPI_data), 32'(vecs[v].data));
         chk("vec_owner", 32'(owner), 32'(vecs[v].idx));
         step();
         chk("vec_wrt_one_cycle", 32'(wrt_SPI), 0);
         chk("vec_pend_cleared", 32'(rq_pend), 0);
         chk("vec_ss_held", 32'(ss), 32'(vecs[v].sel));
         while (cyc < c + vecs[v].done_off) step();
         SPI_done = 1'b1;
         step();
         SPI_done = 1'b0;
         chk("vec_done", 32'(rq_done), 32'(1 << vecs[v].idx));
         chk("vec_gap_ss", 32'(ss), 32'(SS_NONE));
         for (int g = 1; g < 4; g++) begin
            step();
            chk("vec_gap_ss", 32'(ss), 32'(SS_NONE));
            chk("vec_gap_data", 32'(SPI_data), 0);
            chk("vec_done_one_cycle", 32'(rq_done), 0);
         end
         step();
         chk("vec_idle_after_gap", 32'(dut.state), 32'(IDLE));
      end

      // contention after reset: req0 first, then alternate, then req0 again
      rst = 1'b1; step(); rst = 1'b0;
      rq_ss0 = SS_GAIN; rq_data0 = 16'h0101; rq_ss1 = SS_TRIGGER; rq_data1 = 16'h0202;
      pulse(2'b11);
      serve("cont_first", 1'b0, 16'h0101, SS_GAIN, w, d);
      serve("cont_second", 1'b1, 16'h0202, SS_TRIGGER, w2, d2);
      chk("cont_second_cycle", 32'(w2), 32'(d + 6));
      rq_data0 = 16'h0303; rq_data1 = 16'h0404;
      pulse(2'b11);
      serve("cont_again", 1'b0, 16'h0303, SS_GAIN, w3, d3);
      chk("cont_again_cycle", 32'(w3), 32'(d2 + 6));
      serve("cont_again2", 1'b1, 16'h0404, SS_TRIGGER, w, d);

      // lock: follow-up from req0 beats pending req1
      rq_lock = 2'b01;
      rq_ss0 = SS_EEPROM; rq_data0 = 16'h0500; rq_ss1 = SS_GAIN; rq_data1 = 16'h2222;
      pulse(2'b11);
      serve("lock_first", 1'b0, 16'h0500, SS_EEPROM, w, d);
      repeat (3) step();
      rq_data0 = 16'h0000;
      pulse(2'b01);
      rq_lock = 2'b00;
      serve("lock_follow", 1'b0, 16'h0000, SS_EEPROM, w2, d2);
      chk("lock_follow_cycle", 32'(w2), 32'(d + 6));
      chk("lock_req1_kept", 32'(rq_pend), 32'd2);
      serve("lock_release", 1'b1, 16'h2222, SS_GAIN, w3, d3);
      chk("lock_release_cycle", 32'(w3), 32'(d2 + 6));

      // lock timeout: owner never returns
      rq_lock = 2'b01;
      rq_data0 = 16'h0600; rq_data1 = 16'h3333;
      pulse(2'b11);
      serve("tmo_first", 1'b0, 16'h0600, SS_EEPROM, w, d);
      rq_lock = 2'b00;
      serve("tmo_req1", 1'b1, 16'h3333, SS_GAIN, w2, d2);
      chk("tmo_req1_cycle", 32'(w2), 32'(d + 15));

      // overflow, plus re-arm accepted during the issuing cycle
      rq_ss0 = SS_TRIGGER; rq_data0 = 16'h0700;
      pulse(2'b01);
      wait_wrt("ovf_first", w);
      chk("ovf_first_data", 32'(SPI_data), 32'h0700);
      rq_data0 = 16'h0701;
      pulse(2'b01);
      chk("ovf_rearm_pend0", 32'(rq_pend[0]), 1);
      chk("ovf_rearm_no_ovf0", 32'(rq_ovf[0]), 0);
      rq_data1 = 16'hAAAA;
      pulse(2'b10);
      rq_data1 = 16'hBBBB;
      pulse(2'b10);
      chk("ovf_flag", 32'(rq_ovf), 32'd2);
      chk("ovf_pend", 32'(rq_pend), 32'd3);
      SPI_done = 1'b1; step(); SPI_done = 1'b0;
      chk("ovf_first_done", 32'(rq_done), 32'd1);
      serve("ovf_req1", 1'b1, 16'hAAAA, SS_GAIN, w, d);
      serve("ovf_req0", 1'b0, 16'h0701, SS_TRIGGER, w2, d2);
      chk("ovf_sticky", 32'(rq_ovf), 32'd2);

      // reset during WAIT_DONE with req1 pending
      rq_data0 = 16'h0800;
      pulse(2'b01);
      wait_wrt("mid_first", w);
      step();
      rq_data1 = 16'h4444;
      pulse(2'b10);
      chk("mid_pend_before", 32'(rq_pend), 32'd2);
      rst = 1'b1; step(); rst = 1'b0;
      chk("mid_rst_flags", {26'd0, rq_pend, rq_ovf, rq_done}, 0);
      chk("mid_rst_wrt", 32'(wrt_SPI), 0);
      chk("mid_rst_ss", 32'(ss), 32'(SS_NONE));
      chk("mid_rst_data", 32'(SPI_data), 0);
      chk("mid_rst_owner", 32'(owner), 0);
      SPI_done = 1'b1; step(); SPI_done = 1'b0;
      chk("mid_late_done", 32'(rq_done), 0);
      step();
      chk("mid_late_done2", 32'(rq_done), 0);
      chk("mid_no_wrt", 32'(wrt_SPI), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
